// File: rtl/stop_it_pkg.sv
// Shared types and constants for the Stop-It round controller.
package stop_it_pkg;

  localparam int RAND_W    = 5;
  localparam int SCORE_W   = 4;
  localparam int COUNT_MAX = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCRAMBLE,
    S_LATCH,
    S_SHOW,
    S_COUNT,
    S_WIN,
    S_LOSE
  } state_e;

  // Streak increment that sticks at the all-ones value.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/stop_it_ctrl_tick_gen.sv
// Divider producing a one-cycle tick every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/stop_it_ctrl.sv
// Stop-It round controller: draws a target from the external lfsr, runs
// the visible counter and judges the player's stop press.
module stop_it_ctrl
  import stop_it_pkg::*;
#(
  parameter int SCRAMBLE_CYCLES = 8,
  parameter int SHOW_CYCLES     = 16,
  parameter int TICK_DIV        = 4,
  parameter int MAX_LAPS        = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [RAND_W-1:0] rand_i,
  output logic              next_o,
  output logic [RAND_W-1:0] target_o,
  output logic [4:0]        count_o,
  output logic              busy_o,
  output logic              win_o,
  output logic              lose_o,
  output logic [SCORE_W-1:0] score_o
);

  state_e               state_q;
  logic [7:0]           scr_cnt_q;
  logic [15:0]          show_cnt_q;
  logic [3:0]           lap_q, lap_d;
  logic [4:0]           count_q, count_d;
  logic [RAND_W-1:0]    target_q;
  logic [SCORE_W-1:0]   score_q;
  logic                 next_q, busy_q, win_q, lose_q;
  logic                 tick, wrap, timeout;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q == S_LATCH),
    .en_i   (state_q == S_COUNT),
    .tick_o (tick)
  );

  // Counter advance and lap bookkeeping for the current tick.
  always_comb begin
    count_d = count_q + 5'd1;
    wrap    = tick && (count_q == 5'(COUNT_MAX));
    lap_d   = lap_q + 4'd1;
    timeout = wrap && (lap_d == 4'(MAX_LAPS));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      scr_cnt_q  <= '0;
      show_cnt_q <= '0;
      lap_q      <= '0;
      count_q    <= '0;
      target_q   <= '0;
      score_q    <= '0;
      next_q     <= 1'b0;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start_i) begin
            state_q   <= S_SCRAMBLE;
            scr_cnt_q <= '0;
            next_q    <= 1'b1;
            busy_q    <= 1'b1;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
          end
        end
        S_SCRAMBLE: begin
          if (scr_cnt_q == 8'(SCRAMBLE_CYCLES - 1)) begin
            state_q <= S_LATCH;
            next_q  <= 1'b0;
          end else begin
            scr_cnt_q <= scr_cnt_q + 8'd1;
          end
        end
        S_LATCH: begin
          target_q   <= rand_i;
          count_q    <= '0;
          lap_q      <= '0;
          show_cnt_q <= '0;
          state_q    <= S_SHOW;
        end
        S_SHOW: begin
          if (show_cnt_q == 16'(SHOW_CYCLES - 1)) state_q <= S_COUNT;
          else show_cnt_q <= show_cnt_q + 16'd1;
        end
        S_COUNT: begin
          // A stop press is judged on the pre-tick count and beats a timeout.
          if (stop_i) begin
            busy_q <= 1'b0;
            if (count_q == target_q) begin
              state_q <= S_WIN;
              win_q   <= 1'b1;
              score_q <= sat_inc(score_q);
            end else begin
              state_q <= S_LOSE;
              lose_q  <= 1'b1;
              score_q <= '0;
            end
          end else if (tick) begin
            count_q <= count_d;
            if (wrap) lap_q <= lap_d;
            if (timeout) begin
              state_q <= S_LOSE;
              lose_q  <= 1'b1;
              busy_q  <= 1'b0;
              score_q <= '0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign next_o   = next_q;
  assign target_o = target_q;
  assign count_o  = count_q;
  assign busy_o   = busy_q;
  assign win_o    = win_q;
  assign lose_o   = lose_q;
  assign score_o  = score_q;

endmodule
